// File: rtl/srrc_fir_pkg.sv
`default_nettype none
// ============================================================================
// Module   : srrc_fir_pkg
// Purpose  : Shared constants, state encoding and default RRC taps for srrc_fir_mac
// Revision : 1.0
// ============================================================================
package srrc_fir_pkg;

  localparam int DATA_W   = 16;
  localparam int FRAC     = 13;
  localparam int ACC_W    = 32;
  localparam int MAX_TAPS = 64;

  localparam logic signed [ACC_W-1:0] SAT_MAX = 32'sd32767;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -32'sd32768;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  // Symmetric 17-tap root-raised-cosine, centred on index 8; tail entries unused
  localparam logic [DATA_W-1:0] DEFAULT_COEF [MAX_TAPS] = '{
    16'hFF9C, 16'hFF60, 16'hFFD8, 16'h00F0, 16'h0280, 16'h044C, 16'h05F0, 16'h0708,
    16'h076C, 16'h0708, 16'h05F0, 16'h044C, 16'h0280, 16'h00F0, 16'hFFD8, 16'hFF60,
    16'hFF9C, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
    16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
    16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
    16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
    16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
    16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000
  };

endpackage
`default_nettype wire

// File: rtl/srrc_coef_ram.sv
`default_nettype none
// ============================================================================
// Module   : srrc_coef_ram
// Purpose  : NTAPS-entry coefficient register file, sync write / async read
// Revision : 1.0
// ============================================================================
module srrc_coef_ram
  import srrc_fir_pkg::*;
#(
  parameter int NTAPS = 17,
  parameter int TAP_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [5:0]        wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [TAP_W-1:0]  rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] coef_q [NTAPS];
  logic              w_addr_ok;

  // Widened compare so NTAPS=64 does not wrap to zero
  assign w_addr_ok = ({1'b0, wr_addr_i} < 7'(NTAPS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAPS; i++) coef_q[i] <= DEFAULT_COEF[i];
    end else if (we_i && w_addr_ok) begin
      coef_q[wr_addr_i[TAP_W-1:0]] <= wr_data_i;
    end
  end

  assign rd_data_o = coef_q[rd_addr_i];

endmodule
`default_nettype wire

// File: rtl/srrc_fir_mac.sv
`default_nettype none
// ============================================================================
// Module   : srrc_fir_mac
// Purpose  : Time-multiplexed Q2.13 pulse-shaping FIR, one MAC per clock
// Revision : 1.0
// ============================================================================
module srrc_fir_mac
  import srrc_fir_pkg::*;
#(
  parameter int NTAPS = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_sample_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_sample_o,
  input  logic              out_ready_i,
  input  logic              coef_we_i,
  input  logic [5:0]        coef_addr_i,
  input  logic [DATA_W-1:0] coef_data_i
);

  localparam int TAP_W = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam logic [TAP_W-1:0] c_last_tap = TAP_W'(NTAPS - 1);

  logic [1:0]               state_q, state_d;
  logic [DATA_W-1:0]        x_q [NTAPS];
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [TAP_W-1:0]         tap_q, tap_d;
  logic                     out_valid_q, out_valid_d;
  logic [DATA_W-1:0]        out_sample_q, out_sample_d;

  logic                     w_accept;
  logic                     w_coef_we;
  logic [DATA_W-1:0]        w_coef;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_acc_sum;
  logic [DATA_W-1:0]        w_sat;

  assign in_ready_o   = (state_q == ST_IDLE);
  assign w_accept     = in_valid_i && in_ready_o;
  assign w_coef_we    = coef_we_i && (state_q == ST_IDLE);
  assign out_valid_o  = out_valid_q;
  assign out_sample_o = out_sample_q;

  srrc_coef_ram #(
    .NTAPS (NTAPS),
    .TAP_W (TAP_W)
  ) u_coef_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (w_coef_we),
    .wr_addr_i (coef_addr_i),
    .wr_data_i (coef_data_i),
    .rd_addr_i (tap_q),
    .rd_data_o (w_coef)
  );

  // Floor (arithmetic) shift of the full product, then sign-extend
  assign w_prod     = $signed(x_q[tap_q]) * $signed(w_coef);
  assign w_prod_ext = ACC_W'(w_prod >>> FRAC);
  assign w_acc_sum  = acc_q + w_prod_ext;

  always_comb begin
    if (w_acc_sum > SAT_MAX)      w_sat = SAT_MAX[DATA_W-1:0];
    else if (w_acc_sum < SAT_MIN) w_sat = SAT_MIN[DATA_W-1:0];
    else                          w_sat = w_acc_sum[DATA_W-1:0];
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    tap_d        = tap_q;
    out_valid_d  = out_valid_q;
    out_sample_d = out_sample_q;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          acc_d   = '0;
          tap_d   = '0;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        acc_d = w_acc_sum;
        tap_d = tap_q + 1'b1;
        if (tap_q == c_last_tap) begin
          tap_d        = '0;
          state_d      = ST_OUT;
          out_valid_d  = 1'b1;
          out_sample_d = w_sat;
        end
      end
      ST_OUT: begin
        if (out_ready_i) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      acc_q        <= '0;
      tap_q        <= '0;
      out_valid_q  <= 1'b0;
      out_sample_q <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      tap_q        <= tap_d;
      out_valid_q  <= out_valid_d;
      out_sample_q <= out_sample_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NTAPS; k++) x_q[k] <= '0;
    end else if (w_accept) begin
      for (int k = NTAPS - 1; k > 0; k--) x_q[k] <= x_q[k-1];
      x_q[0] <= in_sample_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_srrc_fir_mac.sv
`default_nettype none
// ============================================================================
// Module   : tb_srrc_fir_mac
// Purpose  : Directed self-checking bench for srrc_fir_mac
// Revision : 1.0
// ============================================================================
module tb_srrc_fir_mac;

  localparam int NTAPS = 17;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_sample;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_sample;
  logic        out_ready;
  logic        coef_we;
  logic [5:0]  coef_addr;
  logic [15:0] coef_data;

  logic [15:0] c_default [NTAPS] = '{
    16'hFF9C, 16'hFF60, 16'hFFD8, 16'h00F0, 16'h0280, 16'h044C, 16'h05F0, 16'h0708,
    16'h076C, 16'h0708, 16'h05F0, 16'h044C, 16'h0280, 16'h00F0, 16'hFFD8, 16'hFF60,
    16'hFF9C
  };

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  srrc_fir_mac #(.NTAPS(NTAPS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid_i   (in_valid),
    .in_sample_i  (in_sample),
    .in_ready_o   (in_ready),
    .out_valid_o  (out_valid),
    .out_sample_o (out_sample),
    .out_ready_i  (out_ready),
    .coef_we_i    (coef_we),
    .coef_addr_i  (coef_addr),
    .coef_data_i  (coef_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    n_checks++;
    if (obs !== expd) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, expd);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_sample = '0; out_ready = 1'b1;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic write_coef(input logic [5:0] addr, input logic [15:0] data);
    coef_we = 1'b1; coef_addr = addr; coef_data = data;
    tick();
    coef_we = 1'b0;
  endtask

  task automatic run_sample(input logic [15:0] x, input bit bp,
                            input bit hs_we, input logic [5:0] hs_addr, input logic [15:0] hs_data,
                            input bit mac_we, input logic [5:0] mac_addr, input logic [15:0] mac_data,
                            output logic [15:0] y);
    int w;
    y = 16'h0000;
    in_valid = 1'b1; in_sample = x;
    w = 0;
    while (!in_ready && w < 100) begin tick(); w++; end
    if (!in_ready) begin
      check("in_ready_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    if (hs_we) begin coef_we = 1'b1; coef_addr = hs_addr; coef_data = hs_data; end
    if (bp) out_ready = 1'b0;
    tick();
    in_valid = 1'b0; coef_we = 1'b0;
    if (mac_we) begin
      coef_we = 1'b1; coef_addr = mac_addr; coef_data = mac_data;
      tick();
      coef_we = 1'b0;
    end
    w = 0;
    while (!out_valid && w < 100) begin tick(); w++; end
    if (!out_valid) begin
      check("out_valid_timeout", 0, 1);
      out_ready = 1'b1;
      return;
    end
    y = out_sample;
    if (bp) begin
      for (int i = 0; i < 5; i++) begin
        tick();
        check("bp_sample_stable", out_sample, y);
        check("bp_valid_held", out_valid, 1);
        check("bp_in_ready_low", in_ready, 0);
      end
      out_ready = 1'b1;
      tick();
      check("bp_in_ready_return", in_ready, 1);
      check("bp_valid_drop", out_valid, 0);
    end else begin
      tick();
    end
  endtask

  task automatic send(input logic [15:0] x, output logic [15:0] y);
    run_sample(x, 1'b0, 1'b0, 6'd0, 16'h0, 1'b0, 6'd0, 16'h0, y);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [15:0] y;
    int hs[$];
    int ov[$];
    int cnt;
    int w;

    // Reset state
    rst_n = 1'b0; in_valid = 1'b0; in_sample = '0; out_ready = 1'b1;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    tick(); tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sample", out_sample, 0);
    rst_n = 1'b1;
    tick();

    // Impulse through default taps, with backpressure on one output
    for (int k = 0; k < NTAPS; k++) begin
      run_sample((k == 0) ? 16'h2000 : 16'h0000, (k == 3), 1'b0, 6'd0, 16'h0,
                 1'b0, 6'd0, 16'h0, y);
      check("imp_default", y, c_default[k]);
    end

    // Throughput and latency with in_valid held high
    in_sample = 16'h0000; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (in_ready)  hs.push_back(c);
      if (out_valid) ov.push_back(c);
      tick();
    end
    in_valid = 1'b0;
    w = 0;
    while (!in_ready && w < 100) begin tick(); w++; end
    check("timing_hs_count", (hs.size() >= 3), 1);
    check("timing_ov_count", (ov.size() >= 2), 1);
    if (hs.size() >= 3 && ov.size() >= 2) begin
      check("timing_out_latency", ov[0] - hs[0], NTAPS + 1);
      check("timing_period_a", hs[1] - hs[0], NTAPS + 2);
      check("timing_period_b", hs[2] - hs[1], NTAPS + 2);
      check("timing_out_period", ov[1] - ov[0], NTAPS + 2);
    end

    // Loaded ramp taps; same-cycle write on handshake, ignored writes in MAC / out of range
    do_reset();
    for (int k = 1; k < NTAPS; k++) write_coef(6'(k), 16'(k * 256));
    write_coef(6'd0, 16'h1234);
    write_coef(6'd33, 16'h7777);
    for (int k = 0; k < NTAPS; k++) begin
      run_sample((k == 0) ? 16'h2000 : 16'h0000, 1'b0,
                 (k == 0), 6'd0, 16'h0000,
                 (k == 1), 6'd1, 16'h7777, y);
      check("imp_ramp", y, 16'(k * 256));
    end

    // Floor rounding of a single product
    do_reset();
    for (int k = 0; k < NTAPS; k++) write_coef(6'(k), (k == 0) ? 16'h0001 : 16'h0000);
    send(16'h0001, y);
    check("round_pos_tiny", y, 16'h0000);
    send(16'hFFFF, y);
    check("round_neg_floor", y, 16'hFFFF);

    // Saturation at both rails
    for (int k = 0; k < NTAPS; k++) write_coef(6'(k), 16'h7FFF);
    for (int k = 0; k < NTAPS; k++) send(16'h7FFF, y);
    check("sat_pos", y, 16'h7FFF);
    for (int k = 0; k < NTAPS; k++) send(16'h8000, y);
    check("sat_neg", y, 16'h8000);

    // Asynchronous reset in the middle of a MAC pass
    in_sample = 16'h2000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    check("midmac_in_ready", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check("midmac_rst_out_valid", out_valid, 0);
    check("midmac_rst_in_ready", in_ready, 1);
    check("midmac_rst_out_sample", out_sample, 0);
    tick(); tick();
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      if (out_valid) cnt++;
      tick();
    end
    check("midmac_no_late_output", cnt, 0);
    for (int k = 0; k < NTAPS; k++) begin
      send((k == 0) ? 16'h2000 : 16'h0000, y);
      check("imp_after_reset", y, c_default[k]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/srrc_fir_mac.md
# srrc_fir_mac

Time-multiplexed pulse-shaping FIR for the transmitter. It accepts one Q2.13 symbol sample per handshake and shifts it into an NTAPS-deep delay line. It then runs one multiply-accumulate per clock against a loadable coefficient table and emits one saturated Q2.13 filtered sample per input. It sits between the symbol mapper/upsampler and the DAC/channel interface, and is the stage that supplies symbol/coefficient pairs to the team's Q2.13 multiply arithmetic.

## Interface
- NTAPS, 17, number of filter taps (2..64)
- DATA_W, 16, sample and coefficient width, signed Q2.13
- FRAC, 13, fractional bits; product shift amount
- ACC_W, 32, signed accumulator width
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- in_valid  in  1  input sample present
- in_sample  in  DATA_W  signed Q2.13 upsampled symbol
- in_ready  out  1  block can accept a sample
- out_valid  out  1  filtered sample present
- out_sample  out  DATA_W  signed Q2.13 filtered output
- out_ready  in  1  downstream accepts out_sample
- coef_we  in  1  coefficient write strobe
- coef_addr  in  6  tap index to write
- coef_data  in  DATA_W  signed Q2.13 coefficient

## Operation
- FSM states:
  - IDLE: in_ready=1.
    - On in_valid&&in_ready: x[k]<=x[k-1] for k=NTAPS-1..1, x[0]<=in_sample, acc<=0, tap<=0, then go to MAC.
  - MAC: each cycle acc<=acc+((x[tap]*h[tap])>>>FRAC), tap<=tap+1.
    - The product is a 2*DATA_W signed value, arithmetic-shifted (floor toward -inf) and sign-extended to ACC_W.
    - After tap==NTAPS-1, go to OUT.
  - OUT: out_valid=1, out_sample=sat(acc).
    - On out_ready, go to IDLE.
- sat(): acc>32767 gives 16'h7FFF; acc<-32768 gives 16'h8000; otherwise acc[15:0]. No intermediate saturation is applied.
- in_ready is low in MAC and OUT. Inputs are never dropped silently; upstream holds its sample.
- out_sample and out_valid are registered. out_sample is stable while out_valid=1 and out_ready=0.
- Coefficient writes:
  - Honoured only in IDLE, and only when coef_addr<NTAPS. All other writes are ignored.
  - If coef_we and an input handshake occur in the same IDLE cycle, the write lands first, and the MAC pass that follows uses the new value.
- Reset (asynchronous, any state):
  - state=IDLE, in_ready=1, out_valid=0, out_sample=0.
  - Delay line, acc and tap are cleared to 0.
  - Coefficients are reloaded from the package default table.
  - A reset during MAC or OUT abandons the result; no out_valid pulse follows.

## Timing
- Input accepted at edge T.
- MAC occupies edges T+1..T+NTAPS.
- out_valid=1 from edge T+NTAPS+1.
- With out_ready held at 1: in_ready returns at edge T+NTAPS+2. Throughput is one sample per NTAPS+2 cycles.
- in_ready is combinational from state only, never from in_valid.

## Structure
- Package srrc_fir_pkg holds:
  - the state enum (IDLE, MAC, OUT);
  - the DATA_W/FRAC/ACC_W constants;
  - the SAT_MAX/SAT_MIN constants;
  - DEFAULT_COEF, the 64-entry Q2.13 root-raised-cosine table; the first NTAPS entries are used.
- Sub-module srrc_coef_ram: NTAPS×DATA_W register file with a synchronous write port, an asynchronous read port by tap index, and reset-to-DEFAULT_COEF.
- The multiply/shift and the saturation stay inline in the top level.

## Test plan
- Impulse: load h[k]=k*16'h0100 and send 16'h2000 (1.0) followed by NTAPS-1 zeros.
  - Required: the output sequence equals h[0],h[1],…,h[NTAPS-1], with one out_valid per input.
- Rounding: single tap, h[0]=16'h0001.
  - x=16'h0001 gives out 16'h0000.
  - x=16'hFFFF gives out 16'hFFFF (floor).
- Saturation: all h=16'h7FFF and all x=16'h7FFF gives 16'h7FFF.
  - All x=16'h8000 with h=16'h7FFF gives 16'h8000.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - Required: out_sample constant and in_ready=0 throughout.
  - Required: in_ready=1 one cycle after out_ready rises.
- Timing: with out_ready tied to 1, input accepted at T gives out_valid at exactly T+NTAPS+1, and in_valid held high gives a handshake every NTAPS+2 cycles.
- Reset and writes:
  - Assert rst_n=0 mid-MAC. Required: out_valid=0 immediately, no late output, and the next impulse response equals DEFAULT_COEF.
  - A coef_we during MAC leaves the result unchanged.
